// File: rtl/dsrlzr_beh.sv
// dsrlzr_beh: frames a serial bitstream on sof into WIDTH-bit words behind a one-deep valid/ready buffer
// Ports: clk, rst_n (sync, active-low); sin/sin_en/sof serial input;
//        y[1:WIDTH]/y_vld/y_rdy word output; frm_err mid-frame sof pulse; ovr sticky word drop.
module dsrlzr_beh #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sin,
  input  logic           sin_en,
  input  logic           sof,
  output logic [1:WIDTH] y,
  output logic           y_vld,
  input  logic           y_rdy,
  output logic           frm_err,
  output logic           ovr
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:WIDTH] sreg, sreg_n;
  logic done, ferr, free;
  assign free = !y_vld || y_rdy;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sreg_n = sreg;
    done = 1'b0;
    ferr = 1'b0;
    if (sin_en && sof) begin
      sreg_n[1] = sin;
      cnt_n = CW'(1);
      state_n = SHIFT;
      ferr = state == SHIFT;
    end else if (sin_en && state == SHIFT) begin
      for (int i = 2; i <= WIDTH; i++)
        if (i == int'(cnt) + 1) sreg_n[i] = sin;
      done = int'(cnt) + 1 == WIDTH;
      cnt_n = done ? '0 : cnt + CW'(1);
      state_n = done ? IDLE : SHIFT;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sreg <= '0;
      y <= '0;
      y_vld <= 1'b0;
      frm_err <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sreg <= sreg_n;
      frm_err <= ferr;
      if (done && free) begin
        y <= sreg_n;
        y_vld <= 1'b1;
      end else if (done) begin
        ovr <= 1'b1;
      end else if (y_vld && y_rdy) begin
        y_vld <= 1'b0;
      end
    end
  end
endmodule
